// File: rtl/rdc_watermark.sv
// Per-channel pulse-duration monitor: flags event pulses longer than their weight.
// Optional macro RDC_WATERMARK_EN builds per-channel longest-pulse capture.
module rdc_watermark #(
  parameter int unsigned WEIGHTS_WIDTH = 8,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned N_CORES       = 2,
  parameter int unsigned CORE_EVENTS   = 4,
  parameter int unsigned STICKY        = 1
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              enable_i,
  input  logic                                              clear_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]                    events_i,
  input  logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0]      events_weights_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]                    mask_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]                    ack_i,
  output logic                                              interruption_rdc_o,
  output logic [N_CORES*CORE_EVENTS-1:0]                    interruption_vector_rdc_o,
  output logic [N_CORES*CORE_EVENTS*CNT_WIDTH-1:0]          watermark_o
);

  localparam int unsigned N_CH = N_CORES * CORE_EVENTS;

  if (CNT_WIDTH <= WEIGHTS_WIDTH) begin : g_bad_width
    $error("rdc_watermark: CNT_WIDTH must be greater than WEIGHTS_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_EXCEEDED = 2'd2
  } state_t;

  logic [N_CH-1:0] vec_all;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CNT_WIDTH-1:0]   weight;
    logic                   vec_q, vec_d;
    logic                   viol;
    logic                   run;

    assign weight  = CNT_WIDTH'(events_weights_i[c*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign run     = enable_i & ~clear_i & events_i[c];
    assign viol    = (state_q == ST_EXCEEDED) & ~mask_i[c];

    // Exceed test uses the incremented count so a pulse of exactly weight cycles never trips.
    always_comb begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      if (run) begin
        cnt_d = cnt_inc;
        case (state_q)
          ST_IDLE:     state_d = ST_COUNT;
          ST_COUNT:    state_d = ((weight != '0) && (cnt_d > weight)) ? ST_EXCEEDED : ST_COUNT;
          ST_EXCEEDED: state_d = ST_EXCEEDED;
          default:     state_d = ST_IDLE;
        endcase
      end
    end

    if (STICKY != 0) begin : g_sticky
      always_comb begin
        vec_d = 1'b0;
        if (enable_i && !clear_i) begin
          vec_d = viol | (vec_q & ~ack_i[c]);
        end
      end
    end else begin : g_level
      always_comb begin
        vec_d = 1'b0;
        if (enable_i && !clear_i) begin
          vec_d = viol;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        vec_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        vec_q   <= vec_d;
      end
    end

    assign vec_all[c] = vec_q;

`ifdef RDC_WATERMARK_EN
    logic [CNT_WIDTH-1:0] wm_q, wm_d;

    // Watermark ignores enable_i so calibration data survives a monitor pause.
    always_comb begin
      wm_d = wm_q;
      if (clear_i) begin
        wm_d = '0;
      end else if (cnt_q > wm_q) begin
        wm_d = cnt_q;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wm_q <= '0;
      end else begin
        wm_q <= wm_d;
      end
    end

    assign watermark_o[c*CNT_WIDTH +: CNT_WIDTH] = wm_q;
`else
    assign watermark_o[c*CNT_WIDTH +: CNT_WIDTH] = '0;
`endif
  end

  assign interruption_vector_rdc_o = vec_all;
  assign interruption_rdc_o        = |vec_all;

endmodule

// File: tb/tb_rdc_watermark.sv
// Directed scoreboard bench for rdc_watermark: sticky 16-bit instance and level 9-bit instance.
module tb_rdc_watermark;
  localparam int unsigned NCH = 8;
  localparam int unsigned WW  = 8;
  localparam int unsigned CWA = 16;
  localparam int unsigned CWB = 9;
`ifdef RDC_WATERMARK_EN
  localparam bit WM_ON = 1'b1;
`else
  localparam bit WM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, enable, clear;
  logic [NCH-1:0]     events, mask, ack;
  logic [NCH*WW-1:0]  weights;
  logic               irq_a, irq_b;
  logic [NCH-1:0]     vec_a, vec_b;
  logic [NCH*CWA-1:0] wm_a;
  logic [NCH*CWB-1:0] wm_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rdc_watermark #(
    .WEIGHTS_WIDTH(8), .CNT_WIDTH(16), .N_CORES(2), .CORE_EVENTS(4), .STICKY(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .events_i(events), .events_weights_i(weights), .mask_i(mask), .ack_i(ack),
    .interruption_rdc_o(irq_a), .interruption_vector_rdc_o(vec_a), .watermark_o(wm_a)
  );

  rdc_watermark #(
    .WEIGHTS_WIDTH(8), .CNT_WIDTH(9), .N_CORES(2), .CORE_EVENTS(4), .STICKY(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .events_i(events), .events_weights_i(weights), .mask_i(mask), .ack_i(ack),
    .interruption_rdc_o(irq_b), .interruption_vector_rdc_o(vec_b), .watermark_o(wm_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      total++;
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [63:0] wmw(input logic [63:0] v);
    return WM_ON ? v : 64'd0;
  endfunction

  function automatic logic [63:0] wma(input int c);
    return 64'(wm_a[c*CWA +: CWA]);
  endfunction

  function automatic logic [63:0] wmb(input int c);
    return 64'(wm_b[c*CWB +: CWB]);
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    events = '0; mask = '0; ack = '0; weights = '0;
    #12 rst = 1'b0;

    push("rst_vec_a", 0); push("rst_irq_a", 0); push("rst_wm_a", 0); push("rst_vec_b", 0);
    check(64'(vec_a)); check(64'(irq_a)); check(64'(|wm_a)); check(64'(vec_b));

    // weight 3, five-cycle pulse on ch0
    weights[0*WW +: WW] = 8'd3;
    events[0] = 1'b1;
    push("t1_pre_vec_a", 0);
    tick(4); check(64'(vec_a));
    push("t1_vec_a", 1); push("t1_irq_a", 1); push("t1_vec_b", 1);
    tick(1); check(64'(vec_a)); check(64'(irq_a)); check(64'(vec_b));
    events[0] = 1'b0;
    push("t1_hold1_a", 1); push("t1_hold1_b", 1);
    tick(1); check(64'(vec_a)); check(64'(vec_b));
    push("t1_hold2_a", 1); push("t1_fall_b", 0);
    tick(1); check(64'(vec_a)); check(64'(vec_b));
    push("t1_sticky_a", 1);
    tick(2); check(64'(vec_a));
    ack[0] = 1'b1;
    push("t1_ack_a", 0);
    tick(1); ack[0] = 1'b0; check(64'(vec_a));
    push("t1_wm0_a", wmw(5)); check(wma(0));

    // enable drop with vector 0x81
    weights[7*WW +: WW] = 8'd2;
    events[0] = 1'b1; events[7] = 1'b1;
    push("en_vec_a", 'h81); push("en_vec_b", 'h81);
    tick(5); check(64'(vec_a)); check(64'(vec_b));
    enable = 1'b0;
    push("en_off_vec_a", 0); push("en_off_irq_a", 0); push("en_off_vec_b", 0); push("en_off_irq_b", 0);
    tick(1); check(64'(vec_a)); check(64'(irq_a)); check(64'(vec_b)); check(64'(irq_b));
    push("en_hold_wm0", wmw(5)); push("en_hold_wm7", wmw(5)); push("en_hold_vec_a", 0);
    tick(2); check(wma(0)); check(wma(7)); check(64'(vec_a));
    events = '0; enable = 1'b1;
    tick(2);

    // clear wipes watermarks
    clear = 1'b1;
    push("clr_wm0", 0); push("clr_wm7", 0); push("clr_vec_a", 0);
    tick(1); clear = 1'b0;
    check(wma(0)); check(wma(7)); check(64'(vec_a));

    // exactly weight cycles never exceeds
    push("exact_vec_a", 0); push("exact_vec_b", 0); push("exact_wm0", wmw(3));
    events[0] = 1'b1;
    tick(3); events[0] = 1'b0;
    tick(3); check(64'(vec_a)); check(64'(vec_b)); check(wma(0));

    // weight 0 never exceeds
    events[5] = 1'b1;
    push("w0_vec_a", 0); push("w0_vec_b", 0);
    tick(300); check(64'(vec_a)); check(64'(vec_b));
    events[5] = 1'b0;
    push("w0_wm_a", wmw(300)); push("w0_wm_b", wmw(300));
    tick(2); check(wma(5)); check(wmb(5));

    // saturation: 9-bit counter, weight 255, 600-cycle pulse
    weights[1*WW +: WW] = 8'd255;
    events[1] = 1'b1;
    push("sat_pre_a", 0); push("sat_pre_b", 0);
    tick(256); check(64'(vec_a)); check(64'(vec_b));
    push("sat_irq_a", 2); push("sat_irq_b", 2);
    tick(1); check(64'(vec_a)); check(64'(vec_b));
    tick(343);
    events[1] = 1'b0;
    push("sat_wm_b", wmw(511)); push("sat_wm_a", wmw(600)); push("sat_fall_b", 0); push("sat_sticky_a", 2);
    tick(2); check(wmb(1)); check(wma(1)); check(64'(vec_b)); check(64'(vec_a));
    ack[1] = 1'b1;
    push("sat_ack_a", 0);
    tick(1); ack[1] = 1'b0; check(64'(vec_a));

    // mask and acknowledge on ch2
    weights[2*WW +: WW] = 8'd1;
    mask[2] = 1'b1; events[2] = 1'b1;
    push("msk_vec_a", 0); push("msk_vec_b", 0);
    tick(4); check(64'(vec_a)); check(64'(vec_b));
    mask[2] = 1'b0;
    push("unmask_vec_a", 4); push("unmask_vec_b", 4);
    tick(1); check(64'(vec_a)); check(64'(vec_b));
    ack[2] = 1'b1;
    push("ack_vs_viol_a", 4);
    tick(1); ack[2] = 1'b0; check(64'(vec_a));
    mask[2] = 1'b1;
    push("remask_keep_a", 4); push("remask_b", 0);
    tick(1); check(64'(vec_a)); check(64'(vec_b));
    events[2] = 1'b0;
    tick(1);
    ack[2] = 1'b1;
    push("msk_ack_a", 0);
    tick(1); ack[2] = 1'b0; mask[2] = 1'b0; check(64'(vec_a));

    // asynchronous reset mid-pulse, then restart from zero
    events[0] = 1'b1;
    push("ar_pre_a", 1);
    tick(5); check(64'(vec_a));
    #3 rst = 1'b1;
    #1;
    push("ar_vec_a", 0); push("ar_irq_a", 0); push("ar_wm_a", 0); push("ar_vec_b", 0);
    check(64'(vec_a)); check(64'(irq_a)); check(64'(|wm_a)); check(64'(vec_b));
    #2 rst = 1'b0;
    push("ar_restart_pre", 0);
    tick(4); check(64'(vec_a));
    push("ar_restart_vec", 1);
    tick(1); check(64'(vec_a));
    events = '0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rdc_watermark.md
Name: rdc_watermark

Overview:
Per-channel pulse-duration monitor for contention events, N_CORES x CORE_EVENTS channels. Each channel runs a three-state FSM and a saturating consecutive-high-cycle counter, and flags any pulse longer than its software weight. This block is the parametrised successor of the request duration counter in the MCCU/PMU subsystem. Over the previous generation it adds:
- a separate counter width
- per-channel mask and acknowledge
- a sticky or level interrupt mode
- optional per-channel watermark capture of the longest pulse seen, for weight calibration

Parameters:
WEIGHTS_WIDTH, 8, width of each per-channel weight
CNT_WIDTH, 16, width of each duration counter; must be > WEIGHTS_WIDTH (elaboration error otherwise)
N_CORES, 2, number of cores monitored
CORE_EVENTS, 4, events per core; N_CH = N_CORES*CORE_EVENTS; channel index = core*CORE_EVENTS+event
STICKY, 1, 1 = interrupt vector bits hold until ack/clear/disable; 0 = vector bit mirrors the channel EXCEEDED state one cycle late

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  active-high enable; low forces counters, FSMs and vector to zero/IDLE
clear_i  in  1  synchronous clear of all state including watermarks; priority over everything except rst_i
events_i  in  N_CH  monitored event levels
events_weights_i  in  N_CH*WEIGHTS_WIDTH  channel c at bits [c*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]; 0 = channel never exceeds
mask_i  in  N_CH  1 = channel cannot set its interrupt bit (still counts and watermarks)
ack_i  in  N_CH  per-channel clear of sticky interrupt bit
interruption_rdc_o  out  1  OR of interruption_vector_rdc_o (registered source)
interruption_vector_rdc_o  out  N_CH  per-channel offending-signal flags
watermark_o  out  N_CH*CNT_WIDTH  longest pulse, in cycles, per channel

Behaviour:
- Reset values (rst_i asserted, async): all counters 0, all FSMs IDLE, vector 0, interruption_rdc_o 0, watermark_o 0.
- Counter (per channel):
  - event high and enable_i high: cnt <= cnt+1, saturating at all-ones; never wraps.
  - event low: cnt <= 0.
- FSM states: IDLE, COUNT, EXCEEDED.
  - IDLE -> COUNT: event high and enabled.
  - COUNT -> EXCEEDED: on the edge where the next cnt > weight and weight != 0.
  - COUNT or EXCEEDED -> IDLE: event low.
  - An event high for exactly weight cycles never exceeds.
  - In EXCEEDED the counter keeps counting and saturates.
- Violation: viol[c] = (state==EXCEEDED) & ~mask_i[c]. It is registered into the vector, so the bit rises 1 cycle after entering EXCEEDED, i.e. weight+2 edges after the event is first sampled high.
- STICKY=1: vec[c] <= viol[c] | (vec[c] & ~ack_i[c]). Set dominates when ack and viol coincide.
- STICKY=0: vec[c] <= viol[c]; ack_i is ignored.
- enable_i low: next edge zeroes cnt and vec and forces FSMs to IDLE. Watermarks hold.
- clear_i high: next edge zeroes everything, including watermarks, regardless of enable_i.
- Mask changes take effect on the next edge. Masking does not clear an already-set sticky bit.
- Weight changes mid-pulse are compared against the current cnt immediately.
- rst_i mid-pulse: immediate return to reset values; the pulse restarts counting from 0 after release.

Optional Feature:
RDC_WATERMARK_EN
- Defined: per channel wm[c] <= max(wm[c], cnt[c]) every edge. wm is zeroed only by rst_i or clear_i and held through enable_i low.
- Undefined: no watermark registers are built; watermark_o is tied to 0.

Test Plan:
- Weight 3, ch0 high 5 cycles: cnt 1,2,3,4,5; EXCEEDED after edge 4; vec[0]=1 after edge 5. With STICKY=1 it stays 1 after the event drops, until ack_i[0] pulses; then 0 next edge.
- Weight 3, ch0 high exactly 3 cycles: vec stays 0; watermark_o[ch0]=3 with the macro defined, 0 without.
- Weight 0 on ch5, event held 300 cycles: never interrupts; counter and watermark show 300.
- Counter saturation: CNT_WIDTH 9, weight 255, event held 600 cycles: cnt saturates at 511 with no wrap; interrupt asserted at the edge after cnt=256.
- Masking and acknowledge:
  - mask_i[2]=1, weight 1, event high 4 cycles: no interrupt.
  - Unmask while still high and in EXCEEDED: vec[2]=1 next edge.
  - ack_i[2] in the same cycle as a continuing viol: bit stays 1.
- Boundary controls:
  - enable_i dropped while vec=0x81 and watermarks nonzero: vec=0 and interruption_rdc_o=0 next edge, watermarks held.
  - clear_i pulse: watermarks zero.
  - Async rst_i mid-cycle: all outputs 0 immediately.
  - With STICKY=0, vec[c] falls 1 cycle after the event drops.
